// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with mid-bit sampling, parity/stop checks and a valid/ready output register
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_data_in,
  output logic [DATA_BITS-1:0] rx_data_out,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_error,
  output logic                 stop_error,
  output logic                 overrun_error,
  output logic                 rx_busy
);
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;
  state_t state, state_n;
  logic s1, rx_s, rx_p;
  logic [CW-1:0] cnt;
  logic [3:0] bits;
  logic [DATA_BITS-1:0] shreg;
  logic par_bad, stop_bad, tick, load, drop;
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  assign tick = cnt == CW'(state == START ? HALF - 1 : CLKS_PER_BIT - 1);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (rx_p && !rx_s) state_n = START;
      START:   if (tick) state_n = rx_s ? IDLE : DATA;
      DATA:    if (tick && bits == 4'(DATA_BITS - 1)) state_n = PARITY_EN != 0 ? PARITY : STOP;
      PARITY:  if (tick) state_n = STOP;
      STOP:    if (tick && bits == 4'(STOP_BITS - 1)) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  // A finished frame is only taken when the output register is free or being emptied this cycle
  always_comb begin
    load    = state == DONE && (!rx_valid || rx_ready);
    drop    = state == DONE && rx_valid && !rx_ready;
    rx_busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1            <= 1'b1;
      rx_s          <= 1'b1;
      rx_p          <= 1'b1;
      cnt           <= '0;
      bits          <= '0;
      shreg         <= '0;
      par_bad       <= 1'b0;
      stop_bad      <= 1'b0;
      rx_data_out   <= '0;
      rx_valid      <= 1'b0;
      parity_error  <= 1'b0;
      stop_error    <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      s1            <= rx_data_in;
      rx_s          <= s1;
      rx_p          <= rx_s;
      cnt           <= (state == IDLE || tick || state_n != state) ? '0 : cnt + 1'b1;
      bits          <= (state_n != state) ? '0 : bits + 4'(tick);
      overrun_error <= drop;
      rx_valid      <= load || (rx_valid && !rx_ready);
      if (state == DATA && tick) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      if (state == START) begin
        par_bad  <= 1'b0;
        stop_bad <= 1'b0;
      end
      if (state == PARITY && tick) par_bad <= (^shreg ^ rx_s) != 1'(PARITY_ODD);
      if (state == STOP && tick && !rx_s) stop_bad <= 1'b1;
      if (load) begin
        rx_data_out  <= shreg;
        parity_error <= par_bad;
        stop_error   <= stop_bad;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: scoreboard bench for two receiver configurations (8E1 @16 and 7O2 @8)
module tb_uart_rx_param;
  logic clk = 1'b0, reset = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1, ready_a = 1'b1, ready_b = 1'b1;
  logic [7:0] dout_a;
  logic [6:0] dout_b;
  logic valid_a, pe_a, se_a, ov_err_a, busy_a;
  logic valid_b, pe_b, se_b, ov_err_b, busy_b;
  typedef struct {logic [8:0] d; logic pe; logic se;} exp_t;
  exp_t qa[$], qb[$];
  int checks = 0, errors = 0, ov_a = 0, ov_b = 0;

  always #5 clk = ~clk;

  uart_rx_param dut_a (
    .clk(clk), .reset(reset), .rx_data_in(rx_a), .rx_data_out(dout_a), .rx_valid(valid_a),
    .rx_ready(ready_a), .parity_error(pe_a), .stop_error(se_a), .overrun_error(ov_err_a), .rx_busy(busy_a));

  uart_rx_param #(.CLKS_PER_BIT(8), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset(reset), .rx_data_in(rx_b), .rx_data_out(dout_b), .rx_valid(valid_b),
    .rx_ready(ready_b), .parity_error(pe_b), .stop_error(se_b), .overrun_error(ov_err_b), .rx_busy(busy_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitors sample mid-cycle; stimulus changes just after the rising edge
  always @(negedge clk) if (!reset) begin
    if (ov_err_a) ov_a++;
    if (valid_a && qa.size() == 0) begin
      if (ready_a) chk("a_unexpected_word", {24'd0, dout_a}, 32'hDEAD);
    end else if (valid_a) begin
      chk("a_data", {24'd0, dout_a}, {23'd0, qa[0].d});
      chk("a_parity_error", {31'd0, pe_a}, {31'd0, qa[0].pe});
      chk("a_stop_error", {31'd0, se_a}, {31'd0, qa[0].se});
      if (ready_a) void'(qa.pop_front());
    end
  end

  always @(negedge clk) if (!reset) begin
    if (ov_err_b) ov_b++;
    if (valid_b && qb.size() == 0) begin
      if (ready_b) chk("b_unexpected_word", {25'd0, dout_b}, 32'hDEAD);
    end else if (valid_b) begin
      chk("b_data", {25'd0, dout_b}, {23'd0, qb[0].d});
      chk("b_parity_error", {31'd0, pe_b}, {31'd0, qb[0].pe});
      chk("b_stop_error", {31'd0, se_b}, {31'd0, qb[0].se});
      if (ready_b) void'(qb.pop_front());
    end
  end

  task automatic push_a(input logic [8:0] d, input logic pe, input logic se);
    qa.push_back('{d, pe, se});
  endtask

  task automatic push_b(input logic [8:0] d, input logic pe, input logic se);
    qb.push_back('{d, pe, se});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit sel, input logic v, input int cpb);
    if (sel) rx_b = v;
    else rx_a = v;
    idle(cpb);
  endtask

  task automatic send(input bit sel, input logic [8:0] data, input bit flip, input logic [1:0] stops);
    int nd = sel ? 7 : 8;
    int cpb = sel ? 8 : 16;
    int ns = sel ? 2 : 1;
    logic par = 1'b0;
    for (int i = 0; i < nd; i++) par ^= data[i];
    if (sel) par = ~par;
    par ^= flip;
    drive(sel, 1'b0, cpb);
    for (int i = 0; i < nd; i++) drive(sel, data[i], cpb);
    drive(sel, par, cpb);
    for (int i = 0; i < ns; i++) drive(sel, stops[i], cpb);
    if (sel) rx_b = 1'b1;
    else rx_a = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_data", {24'd0, dout_a}, 0);
    chk("rst_a_valid", {31'd0, valid_a}, 0);
    chk("rst_a_flags", {29'd0, pe_a, se_a, ov_err_a}, 0);
    chk("rst_a_busy", {31'd0, busy_a}, 0);
    chk("rst_b_valid", {31'd0, valid_b}, 0);
    chk("rst_b_busy", {31'd0, busy_b}, 0);
    #1;
    reset = 1'b0;
    idle(4);
    // 0xA5, 8E1: rx_valid rises 172 edges after the start bit is driven and lasts one cycle
    push_a(9'h0A5, 1'b0, 1'b0);
    fork
      send(1'b0, 9'h0A5, 1'b0, 2'b11);
      begin
        int n = 0;
        while (!valid_a && n < 400) begin
          @(posedge clk);
          #1;
          n++;
        end
        chk("a_latency", n, 172);
        @(posedge clk);
        #1;
        chk("a_valid_one_cycle", {31'd0, valid_a}, 0);
      end
    join
    idle(8);
    push_a(9'h03C, 1'b1, 1'b0);
    send(1'b0, 9'h03C, 1'b1, 2'b11);
    idle(8);
    push_a(9'h00F, 1'b0, 1'b1);
    send(1'b0, 9'h00F, 1'b0, 2'b00);
    idle(32);
    push_a(9'h055, 1'b0, 1'b0);
    send(1'b0, 9'h055, 1'b0, 2'b11);
    idle(20);
    chk("a_idle_after_errors", {31'd0, busy_a}, 0);
    // Overrun: 0x22 arrives while 0x11 is still held
    ready_a = 1'b0;
    push_a(9'h011, 1'b0, 1'b0);
    send(1'b0, 9'h011, 1'b0, 2'b11);
    send(1'b0, 9'h022, 1'b0, 2'b11);
    idle(10);
    chk("a_overrun_pulses", ov_a, 1);
    chk("a_held_valid", {31'd0, valid_a}, 1);
    chk("a_held_data", {24'd0, dout_a}, 32'h11);
    ready_a = 1'b1;
    idle(1);
    chk("a_valid_dropped", {31'd0, valid_a}, 0);
    push_a(9'h033, 1'b0, 1'b0);
    send(1'b0, 9'h033, 1'b0, 2'b11);
    idle(20);
    chk("a_overrun_total", ov_a, 1);
    // Short glitch: START check sees the line high again and aborts
    rx_a = 1'b0;
    idle(3);
    rx_a = 1'b1;
    idle(2);
    chk("a_glitch_busy", {31'd0, busy_a}, 1);
    idle(20);
    chk("a_glitch_idle", {31'd0, busy_a}, 0);
    chk("a_glitch_no_valid", {31'd0, valid_a}, 0);
    // 7O2: second stop bit low, then a clean resend
    push_b(9'h05A, 1'b0, 1'b1);
    send(1'b1, 9'h05A, 1'b0, 2'b01);
    idle(16);
    push_b(9'h05A, 1'b0, 1'b0);
    send(1'b1, 9'h05A, 1'b0, 2'b11);
    idle(30);
    // Reset in the middle of the data bits of 0xFF
    drive(1'b0, 1'b0, 16);
    drive(1'b0, 1'b1, 16);
    drive(1'b0, 1'b1, 16);
    chk("a_busy_mid_frame", {31'd0, busy_a}, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_a_busy", {31'd0, busy_a}, 0);
    chk("mid_rst_a_valid", {31'd0, valid_a}, 0);
    chk("mid_rst_a_data", {24'd0, dout_a}, 0);
    chk("mid_rst_a_flags", {29'd0, pe_a, se_a, ov_err_a}, 0);
    #1;
    reset = 1'b0;
    idle(40);
    push_a(9'h081, 1'b0, 1'b0);
    send(1'b0, 9'h081, 1'b0, 2'b11);
    idle(20);
    for (int i = 0; i < 400 && (qa.size() != 0 || qb.size() != 0); i++) @(posedge clk);
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    chk("b_no_overrun", ov_b, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
